// File: rtl/operand_stage_pkg.sv
// operand_stage_pkg
// Shared types and constants for the operand-collection stage.
//   fwd_src_t    : one forwarding source (destination, allow, pending, data).
//                  It is sized for the largest supported datapath and address width.
//                  Narrower configurations are zero-extended into it.
//   SEL_*        : operand-select encodings used by the operand muxes.
//   ST_*         : output-register FSM states.
//   operand_sel  : maps decode control bits onto a select encoding.
package operand_stage_pkg;

   localparam int FWD_XLEN_MAX = 32;
   localparam int FWD_RA_W_MAX = 5;

   typedef struct packed {
      logic [FWD_RA_W_MAX-1:0] rd_addr;
      logic                    allow;
      logic                    pending;
      logic [FWD_XLEN_MAX-1:0] data;
   } fwd_src_t;

   localparam logic [1:0] SEL_RS     = 2'd0;
   localparam logic [1:0] SEL_PC_IMM = 2'd1;
   localparam logic [1:0] SEL_ZERO   = 2'd2;

   localparam logic [0:0] ST_EMPTY = 1'b0;
   localparam logic [0:0] ST_FULL  = 1'b1;

   // The alternate source (PC or IMM) wins over the register.
   // With neither in use, the operand is forced to zero (LUI-style).
   function automatic logic [1:0] operand_sel(input logic use_rs, input logic use_alt);
      logic [1:0] sel;
      if (use_alt) begin
         sel = SEL_PC_IMM;
      end else if (use_rs) begin
         sel = SEL_RS;
      end else begin
         sel = SEL_ZERO;
      end
      return sel;
   endfunction

endpackage

// File: rtl/operand_stage_fwd_resolve.sv
// fwd_resolve
// Priority match of one source register against NUM_FWD forwarding sources.
//   use_rs   : the register field is actually read
//   rs_addr  : source register address
//   reg_data : register-file read data (used when nothing matches)
//   src      : forwarding sources; index 0 is the youngest and has the highest priority
//   data     : resolved operand value
//   hazard   : the winning source has no data yet
module fwd_resolve
   import operand_stage_pkg::*;
#(
   parameter int NUM_FWD = 2,
   parameter int XLEN    = 32,
   parameter int RA_W    = 5
) (
   input  logic            use_rs,
   input  logic [RA_W-1:0] rs_addr,
   input  logic [XLEN-1:0] reg_data,
   input  fwd_src_t        src [NUM_FWD],
   output logic [XLEN-1:0] data,
   output logic            hazard
);

   logic [FWD_RA_W_MAX-1:0] rs_ext;
   logic                    found;

   assign rs_ext = FWD_RA_W_MAX'(rs_addr);

   // Lowest-index match wins outright. A pending winner hazards the operand
   // even when an older source holds valid data for the same register.
   always_comb begin
      data   = reg_data;
      hazard = 1'b0;
      found  = 1'b0;
      for (int k = 0; k < NUM_FWD; k++) begin
         if (!found && use_rs && (rs_ext != {FWD_RA_W_MAX{1'b0}}) &&
             (src[k].rd_addr == rs_ext) && (src[k].allow || src[k].pending)) begin
            found = 1'b1;
            if (src[k].pending) begin
               hazard = 1'b1;
            end else begin
               data = src[k].data[XLEN-1:0];
            end
         end else begin
            found = found;
         end
      end
   end

endmodule

// File: rtl/operand_stage.sv
// operand_stage
// Operand collection between decode and execute. RS1/RS2 are resolved against
// the forwarding sources, and decode is stalled on a load-use hazard. The selected
// operands are registered behind a valid/ready handshake.
//   i_clk, i_rst_n         : clock, asynchronous active-low reset
//   i_dcd_valid/o_dcd_ready: decode handshake (ready never depends on valid)
//   i_rs*/i_use_*/i_op_*   : decoded operand controls and register-file data
//   i_pc, i_imm            : alternate operand sources
//   i_fwd_*                : forwarding buses; slice k belongs to source k
//   i_flush                : empties the stage and blocks acceptance
//   o_valid/i_ready        : execute handshake
//   o_operand_a/b          : registered ALU operands
//   o_store_data           : registered resolved RS2
//   o_stall_cnt            : saturating count of hazard-stall cycles
module operand_stage
   import operand_stage_pkg::*;
#(
   parameter int XLEN    = 32,
   parameter int NUM_FWD = 2,
   parameter int RA_W    = 5,
   parameter int CNT_W   = 16
) (
   input  logic                    i_clk,
   input  logic                    i_rst_n,
   input  logic                    i_dcd_valid,
   output logic                    o_dcd_ready,
   input  logic [RA_W-1:0]         i_rs1_addr,
   input  logic [RA_W-1:0]         i_rs2_addr,
   input  logic                    i_use_rs1,
   input  logic                    i_use_rs2,
   input  logic                    i_op_a_use_pc,
   input  logic                    i_op_b_use_imm,
   input  logic [XLEN-1:0]         i_pc,
   input  logic [XLEN-1:0]         i_imm,
   input  logic [XLEN-1:0]         i_rs1_data,
   input  logic [XLEN-1:0]         i_rs2_data,
   input  logic [NUM_FWD*RA_W-1:0] i_fwd_rd_addr,
   input  logic [NUM_FWD-1:0]      i_fwd_allow,
   input  logic [NUM_FWD-1:0]      i_fwd_pending,
   input  logic [NUM_FWD*XLEN-1:0] i_fwd_data,
   input  logic                    i_flush,
   output logic                    o_valid,
   input  logic                    i_ready,
   output logic [XLEN-1:0]         o_operand_a,
   output logic [XLEN-1:0]         o_operand_b,
   output logic [XLEN-1:0]         o_store_data,
   output logic [CNT_W-1:0]        o_stall_cnt
);

   fwd_src_t        fwd [NUM_FWD];
   logic [XLEN-1:0] rs1_val;
   logic [XLEN-1:0] rs2_val;
   logic            rs1_hazard;
   logic            rs2_hazard;
   logic            hazard;
   logic            accept;
   logic [1:0]      sel_a;
   logic [1:0]      sel_b;
   logic [XLEN-1:0] operand_a_nxt;
   logic [XLEN-1:0] operand_b_nxt;
   logic [0:0]      state;
   logic [0:0]      state_nxt;

   // The flat buses are repacked into sources, zero-extended to the package widths.
   for (genvar k = 0; k < NUM_FWD; k++) begin : g_fwd
      assign fwd[k].rd_addr = FWD_RA_W_MAX'(i_fwd_rd_addr[k*RA_W +: RA_W]);
      assign fwd[k].allow   = i_fwd_allow[k];
      assign fwd[k].pending = i_fwd_pending[k];
      assign fwd[k].data    = FWD_XLEN_MAX'(i_fwd_data[k*XLEN +: XLEN]);
   end

   fwd_resolve #(.NUM_FWD(NUM_FWD), .XLEN(XLEN), .RA_W(RA_W)) u_rs1 (
      .use_rs   (i_use_rs1),
      .rs_addr  (i_rs1_addr),
      .reg_data (i_rs1_data),
      .src      (fwd),
      .data     (rs1_val),
      .hazard   (rs1_hazard)
   );

   fwd_resolve #(.NUM_FWD(NUM_FWD), .XLEN(XLEN), .RA_W(RA_W)) u_rs2 (
      .use_rs   (i_use_rs2),
      .rs_addr  (i_rs2_addr),
      .reg_data (i_rs2_data),
      .src      (fwd),
      .data     (rs2_val),
      .hazard   (rs2_hazard)
   );

   assign hazard      = rs1_hazard | rs2_hazard;
   assign o_valid     = (state == ST_FULL);
   assign o_dcd_ready = ~hazard & (~o_valid | i_ready) & ~i_flush;
   assign accept      = i_dcd_valid & o_dcd_ready;
   assign sel_a       = operand_sel(i_use_rs1, i_op_a_use_pc);
   assign sel_b       = operand_sel(i_use_rs2, i_op_b_use_imm);

   // Operand A mux.
   always_comb begin
      case (sel_a)
         SEL_RS:     operand_a_nxt = rs1_val;
         SEL_PC_IMM: operand_a_nxt = i_pc;
         SEL_ZERO:   operand_a_nxt = {XLEN{1'b0}};
         default:    operand_a_nxt = {XLEN{1'b0}};
      endcase
   end

   // Operand B mux.
   always_comb begin
      case (sel_b)
         SEL_RS:     operand_b_nxt = rs2_val;
         SEL_PC_IMM: operand_b_nxt = i_imm;
         SEL_ZERO:   operand_b_nxt = {XLEN{1'b0}};
         default:    operand_b_nxt = {XLEN{1'b0}};
      endcase
   end

   // EMPTY/FULL next-state logic. A flush overrides everything.
   always_comb begin
      state_nxt = state;
      if (i_flush) begin
         state_nxt = ST_EMPTY;
      end else begin
         case (state)
            ST_EMPTY: state_nxt = accept ? ST_FULL : ST_EMPTY;
            ST_FULL: begin
               if (accept) begin
                  state_nxt = ST_FULL;
               end else if (i_ready) begin
                  state_nxt = ST_EMPTY;
               end else begin
                  state_nxt = ST_FULL;
               end
            end
            default: state_nxt = ST_EMPTY;
         endcase
      end
   end

   // State register.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state <= ST_EMPTY;
      end else begin
         state <= state_nxt;
      end
   end

   // The output register loads only on accept, so it holds while execute stalls.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         o_operand_a  <= {XLEN{1'b0}};
         o_operand_b  <= {XLEN{1'b0}};
         o_store_data <= {XLEN{1'b0}};
      end else if (accept) begin
         o_operand_a  <= operand_a_nxt;
         o_operand_b  <= operand_b_nxt;
         o_store_data <= rs2_val;
      end else begin
         o_operand_a  <= o_operand_a;
         o_operand_b  <= o_operand_b;
         o_store_data <= o_store_data;
      end
   end

   // Saturating hazard-stall counter. Flushed cycles are not counted.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         o_stall_cnt <= {CNT_W{1'b0}};
      end else if (i_dcd_valid && hazard && !i_flush && !(&o_stall_cnt)) begin
         o_stall_cnt <= o_stall_cnt + CNT_W'(1);
      end else begin
         o_stall_cnt <= o_stall_cnt;
      end
   end

endmodule
